// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Sequencer for the fetch stage of the 64-bit pipelined ARM CPU. It owns the
// architectural PC register (pc_q) and steers the next-PC datapath through
// its select lines. It arbitrates between sequential fetch, load-use stalls
// and branch redirects coming back from the resolve stage.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   stall_in        - hazard-unit stall request (load-use)
//   br_valid        - a branch resolves this cycle
//   br_kind         - 00 cond, 01 B/BL, 10 BR (register), 11 reserved
//   br_cond_true    - condition outcome for conditional branches
//   br_pc           - PC of the resolving branch
//   next_pc         - datapath next-PC result (used on redirects)
//   norm_result     - datapath pc_base + 4 (used on sequential advance)
//   cur_pc          - PC base driven into the datapath
//   fetch_pc        - registered PC currently being fetched
//   is_BR, UncondBr, BrTaken - datapath target selects
//   fetch_valid     - instruction at fetch_pc goes into IF/ID
//   ifid_hold       - IF/ID keeps its contents
//   ifid_flush      - IF/ID is cleared to NOP
//
// Optional feature (macro FETCH_CTRL_PERF_EN):
//   perf_fetched, perf_redirects, perf_stall_cycles - 32-bit saturating
//   event counters, cleared by reset.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned KILL_SLOTS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        br_valid,
  input  logic [1:0]  br_kind,
  input  logic        br_cond_true,
  input  logic [63:0] br_pc,
  input  logic [63:0] next_pc,
  input  logic [63:0] norm_result,
  output logic [63:0] cur_pc,
  output logic [63:0] fetch_pc,
  output logic        is_BR,
  output logic        UncondBr,
  output logic        BrTaken,
  output logic        fetch_valid,
  output logic        ifid_hold,
  output logic        ifid_flush
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stall_cycles
`endif
);

  localparam logic [1:0] BOOT   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] STALL  = 2'd2;
  localparam logic [1:0] SQUASH = 2'd3;

  // The redirect cycle itself is the first bubble, so SQUASH only needs to
  // cover the remaining KILL_SLOTS cycles; the counter is loaded with one
  // less because SQUASH exits once it sees zero.
  localparam logic [2:0] SQUASH_INIT =
    (KILL_SLOTS > 0) ? 3'(KILL_SLOTS - 1) : 3'd0;

  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  squash_cnt, squash_cnt_d;
  logic        br_active;
  logic        taken;

  // Branch decode is only meaningful while the pipe is live (RUN/STALL);
  // in BOOT and SQUASH any br_valid belongs to an instruction being killed.
  always_comb begin
    br_active = !reset && br_valid && (state_q == RUN || state_q == STALL);
    is_BR     = br_active && (br_kind == 2'b10);
    UncondBr  = br_active && (br_kind == 2'b01);
    BrTaken   = br_active && ((br_kind == 2'b01) ||
                              (br_kind == 2'b00 && br_cond_true));
    taken     = is_BR || BrTaken;
    cur_pc    = reset ? RESET_PC : (taken ? br_pc : pc_q);
    fetch_pc  = reset ? RESET_PC : pc_q;
  end

  // Next-state and IF/ID control. A taken redirect outranks a stall because
  // the stalling instruction is younger than the branch and gets squashed.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    squash_cnt_d = squash_cnt;
    fetch_valid  = 1'b0;
    ifid_hold    = 1'b0;
    ifid_flush   = 1'b0;
    if (reset) begin
      ifid_flush = 1'b1;
    end else begin
      case (state_q)
        BOOT: begin
          ifid_flush = 1'b1;
          state_d    = RUN;
        end
        RUN, STALL: begin
          if (taken) begin
            pc_d       = next_pc;
            ifid_flush = 1'b1;
            if (KILL_SLOTS > 0) begin
              state_d      = SQUASH;
              squash_cnt_d = SQUASH_INIT;
            end else begin
              state_d = RUN;
            end
          end else if (stall_in) begin
            ifid_hold = 1'b1;
            state_d   = STALL;
          end else begin
            pc_d        = norm_result;
            fetch_valid = 1'b1;
            state_d     = RUN;
          end
        end
        default: begin
          ifid_flush = 1'b1;
          if (squash_cnt == 3'd0) begin
            state_d = RUN;
          end else begin
            squash_cnt_d = squash_cnt - 3'd1;
          end
        end
      endcase
    end
  end

  // State registers; reset abandons everything in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      squash_cnt <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      squash_cnt <= squash_cnt_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched      <= 32'd0;
      perf_redirects    <= 32'd0;
      perf_stall_cycles <= 32'd0;
    end else begin
      if (fetch_valid && perf_fetched != 32'hFFFF_FFFF)
        perf_fetched <= perf_fetched + 32'd1;
      if (taken && perf_redirects != 32'hFFFF_FFFF)
        perf_redirects <= perf_redirects + 32'd1;
      if (ifid_hold && perf_stall_cycles != 32'hFFFF_FFFF)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl. Two instances share the branch/stall
// stimulus: u_k0 (KILL_SLOTS=0) and u_k2 (KILL_SLOTS=2), each with its own
// reset and its own behavioural next-PC datapath. While one is exercised the
// other is held in reset. Inputs change on the falling edge and outputs are
// sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam logic [63:0] F_NONE  = 64'h0;
  localparam logic [63:0] F_FLUSH = 64'h1;
  localparam logic [63:0] F_HOLD  = 64'h2;
  localparam logic [63:0] F_VALID = 64'h4;
  localparam logic [63:0] S_NONE  = 64'h0;
  localparam logic [63:0] S_BT    = 64'h1;
  localparam logic [63:0] S_UNC   = 64'h3;
  localparam logic [63:0] S_ISBR  = 64'h4;

  logic        clk;
  logic        reset_k0, reset_k2;
  logic        stall_in, br_valid, br_cond_true;
  logic [1:0]  br_kind;
  logic [63:0] br_pc, br_reg;
  logic [18:0] imm19;
  logic [25:0] imm26;

  logic [63:0] next_pc_k0, norm_k0, cur_pc_k0, fetch_pc_k0;
  logic        is_br_k0, unc_k0, bt_k0, fv_k0, hold_k0, flush_k0;
  logic [63:0] next_pc_k2, norm_k2, cur_pc_k2, fetch_pc_k2;
  logic        is_br_k2, unc_k2, bt_k2, fv_k2, hold_k2, flush_k2;
  logic [63:0] flags_k0, sel_k0, flags_k2, sel_k2;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] pf_k0, pr_k0, ps_k0, pf_k2, pr_k2, ps_k2;
`endif

  int vectors;
  int miscompares;

  // Behavioural datapath: register target, PC-relative Imm26/Imm19, or +4.
  function automatic logic [63:0] datapath(input logic [63:0] base,
                                           input logic isbr, input logic unc,
                                           input logic bt);
    if (isbr)
      return br_reg;
    else if (bt && unc)
      return base + {{36{imm26[25]}}, imm26, 2'b00};
    else if (bt)
      return base + {{43{imm19[18]}}, imm19, 2'b00};
    else
      return base + 64'd4;
  endfunction

  assign norm_k0    = cur_pc_k0 + 64'd4;
  assign next_pc_k0 = datapath(cur_pc_k0, is_br_k0, unc_k0, bt_k0);
  assign norm_k2    = cur_pc_k2 + 64'd4;
  assign next_pc_k2 = datapath(cur_pc_k2, is_br_k2, unc_k2, bt_k2);

  assign flags_k0 = {61'd0, fv_k0, hold_k0, flush_k0};
  assign sel_k0   = {61'd0, is_br_k0, unc_k0, bt_k0};
  assign flags_k2 = {61'd0, fv_k2, hold_k2, flush_k2};
  assign sel_k2   = {61'd0, is_br_k2, unc_k2, bt_k2};

  fetch_ctrl #(.RESET_PC(64'h0), .KILL_SLOTS(0)) u_k0 (
    .clk(clk), .reset(reset_k0), .stall_in(stall_in), .br_valid(br_valid),
    .br_kind(br_kind), .br_cond_true(br_cond_true), .br_pc(br_pc),
    .next_pc(next_pc_k0), .norm_result(norm_k0), .cur_pc(cur_pc_k0),
    .fetch_pc(fetch_pc_k0), .is_BR(is_br_k0), .UncondBr(unc_k0),
    .BrTaken(bt_k0), .fetch_valid(fv_k0), .ifid_hold(hold_k0),
    .ifid_flush(flush_k0)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_fetched(pf_k0), .perf_redirects(pr_k0), .perf_stall_cycles(ps_k0)
`endif
  );

  fetch_ctrl #(.RESET_PC(64'h0), .KILL_SLOTS(2)) u_k2 (
    .clk(clk), .reset(reset_k2), .stall_in(stall_in), .br_valid(br_valid),
    .br_kind(br_kind), .br_cond_true(br_cond_true), .br_pc(br_pc),
    .next_pc(next_pc_k2), .norm_result(norm_k2), .cur_pc(cur_pc_k2),
    .fetch_pc(fetch_pc_k2), .is_BR(is_br_k2), .UncondBr(unc_k2),
    .BrTaken(bt_k2), .fetch_valid(fv_k2), .ifid_hold(hold_k2),
    .ifid_flush(flush_k2)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_fetched(pf_k2), .perf_redirects(pr_k2), .perf_stall_cycles(ps_k2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus: change inputs on the falling edge, then settle.
  task automatic applyStimulus(input logic r0, input logic r2,
                               input logic sv, input logic bv,
                               input logic [1:0] kind, input logic cond,
                               input logic [63:0] bpc, input logic [63:0] breg,
                               input logic [18:0] i19, input logic [25:0] i26);
    @(negedge clk);
    reset_k0     = r0;
    reset_k2     = r2;
    stall_in     = sv;
    br_valid     = bv;
    br_kind      = kind;
    br_cond_true = cond;
    br_pc        = bpc;
    br_reg       = breg;
    imm19        = i19;
    imm26        = i26;
    #1;
  endtask

  task automatic idle(input logic r0, input logic r2);
    applyStimulus(r0, r2, 1'b0, 1'b0, 2'b00, 1'b0, 64'h0, 64'h0, 19'd0, 26'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_k0 = 1'b1; reset_k2 = 1'b1; stall_in = 1'b0; br_valid = 1'b0;
    br_kind = 2'b00; br_cond_true = 1'b0; br_pc = 64'h0; br_reg = 64'h0;
    imm19 = 19'd0; imm26 = 26'd0;

    // ---------------- KILL_SLOTS = 0 instance ----------------
    applyStimulus(1, 1, 1, 1, 2'b01, 0, 64'h40, 64'h0, 19'd0, 26'd4);
    checkOutput("k0 reset flags", flags_k0, F_FLUSH);
    checkOutput("k0 reset sel", sel_k0, S_NONE);
    checkOutput("k0 reset fetch_pc", fetch_pc_k0, 64'h0);
    checkOutput("k0 reset cur_pc", cur_pc_k0, 64'h0);
    idle(1, 1);

    idle(0, 1);
    checkOutput("k0 boot flags", flags_k0, F_FLUSH);
    checkOutput("k0 boot fetch_pc", fetch_pc_k0, 64'h0);
    idle(0, 1);
    checkOutput("k0 run0 flags", flags_k0, F_VALID);
    checkOutput("k0 run0 fetch_pc", fetch_pc_k0, 64'h0);
    idle(0, 1);
    checkOutput("k0 run4 fetch_pc", fetch_pc_k0, 64'h4);
    idle(0, 1);
    checkOutput("k0 run8 fetch_pc", fetch_pc_k0, 64'h8);
    idle(0, 1);
    checkOutput("k0 runC fetch_pc", fetch_pc_k0, 64'hC);
    checkOutput("k0 runC flags", flags_k0, F_VALID);

    // Conditional taken: target 0x8 + 3*4 = 0x14.
    applyStimulus(0, 1, 0, 1, 2'b00, 1, 64'h8, 64'h0, 19'd3, 26'd0);
    checkOutput("k0 bcond fetch_pc", fetch_pc_k0, 64'h10);
    checkOutput("k0 bcond flags", flags_k0, F_FLUSH);
    checkOutput("k0 bcond sel", sel_k0, S_BT);
    checkOutput("k0 bcond cur_pc", cur_pc_k0, 64'h8);
    // Conditional not taken: sequential.
    applyStimulus(0, 1, 0, 1, 2'b00, 0, 64'h10, 64'h0, 19'd3, 26'd0);
    checkOutput("k0 bnt fetch_pc", fetch_pc_k0, 64'h14);
    checkOutput("k0 bnt flags", flags_k0, F_VALID);
    checkOutput("k0 bnt sel", sel_k0, S_NONE);
    checkOutput("k0 bnt cur_pc", cur_pc_k0, 64'h14);
    // Register branch to 0x200.
    applyStimulus(0, 1, 0, 1, 2'b10, 0, 64'h18, 64'h200, 19'd0, 26'd0);
    checkOutput("k0 br fetch_pc", fetch_pc_k0, 64'h18);
    checkOutput("k0 br sel", sel_k0, S_ISBR);
    checkOutput("k0 br flags", flags_k0, F_FLUSH);
    // Unconditional B from 0x40 with Imm26 = -1: target 0x3C.
    applyStimulus(0, 1, 0, 1, 2'b01, 0, 64'h40, 64'h0, 19'd0, 26'h3FFFFFF);
    checkOutput("k0 b fetch_pc", fetch_pc_k0, 64'h200);
    checkOutput("k0 b sel", sel_k0, S_UNC);
    checkOutput("k0 b cur_pc", cur_pc_k0, 64'h40);
    // Reserved kind behaves as not taken.
    applyStimulus(0, 1, 0, 1, 2'b11, 1, 64'h3C, 64'h999, 19'd0, 26'd0);
    checkOutput("k0 rsvd fetch_pc", fetch_pc_k0, 64'h3C);
    checkOutput("k0 rsvd sel", sel_k0, S_NONE);
    checkOutput("k0 rsvd flags", flags_k0, F_VALID);
    // Not-taken branch with stall: stall applies; three stall cycles.
    applyStimulus(0, 1, 1, 1, 2'b00, 0, 64'h40, 64'h0, 19'd5, 26'd0);
    checkOutput("k0 stall1 fetch_pc", fetch_pc_k0, 64'h40);
    checkOutput("k0 stall1 flags", flags_k0, F_HOLD);
    applyStimulus(0, 1, 1, 0, 2'b00, 0, 64'h0, 64'h0, 19'd0, 26'd0);
    checkOutput("k0 stall2 flags", flags_k0, F_HOLD);
    applyStimulus(0, 1, 1, 0, 2'b00, 0, 64'h0, 64'h0, 19'd0, 26'd0);
    checkOutput("k0 stall3 fetch_pc", fetch_pc_k0, 64'h40);
    checkOutput("k0 stall3 flags", flags_k0, F_HOLD);
    idle(0, 1);
    checkOutput("k0 unstall fetch_pc", fetch_pc_k0, 64'h40);
    checkOutput("k0 unstall flags", flags_k0, F_VALID);
    // Stall, then a taken B in the second stall cycle: 0x44 + 4*4 = 0x54.
    applyStimulus(0, 1, 1, 0, 2'b00, 0, 64'h0, 64'h0, 19'd0, 26'd0);
    checkOutput("k0 istall fetch_pc", fetch_pc_k0, 64'h44);
    checkOutput("k0 istall flags", flags_k0, F_HOLD);
    applyStimulus(0, 1, 1, 1, 2'b01, 0, 64'h44, 64'h0, 19'd0, 26'd4);
    checkOutput("k0 stall+b flags", flags_k0, F_FLUSH);
    checkOutput("k0 stall+b sel", sel_k0, S_UNC);
    // Taken BR with stall while in RUN: redirect wins.
    applyStimulus(0, 1, 1, 1, 2'b10, 0, 64'h54, 64'h80, 19'd0, 26'd0);
    checkOutput("k0 run+br fetch_pc", fetch_pc_k0, 64'h54);
    checkOutput("k0 run+br flags", flags_k0, F_FLUSH);
    // Redirect to the top of the address space, then wrap to 0.
    applyStimulus(0, 1, 0, 1, 2'b10, 0, 64'h80, 64'hFFFF_FFFF_FFFF_FFFC,
                  19'd0, 26'd0);
    checkOutput("k0 br80 fetch_pc", fetch_pc_k0, 64'h80);
    idle(0, 1);
    checkOutput("k0 top fetch_pc", fetch_pc_k0, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("k0 top flags", flags_k0, F_VALID);
    idle(0, 1);
    checkOutput("k0 wrap fetch_pc", fetch_pc_k0, 64'h0);
    checkOutput("k0 wrap flags", flags_k0, F_VALID);
    applyStimulus(0, 1, 1, 0, 2'b00, 0, 64'h0, 64'h0, 19'd0, 26'd0);
    checkOutput("k0 pre-rst fetch_pc", fetch_pc_k0, 64'h4);
    checkOutput("k0 pre-rst flags", flags_k0, F_HOLD);
`ifdef FETCH_CTRL_PERF_EN
    checkOutput("k0 perf_fetched", 64'(pf_k0), 64'd9);
    checkOutput("k0 perf_redirects", 64'(pr_k0), 64'd6);
    checkOutput("k0 perf_stall_cycles", 64'(ps_k0), 64'd4);
`endif
    // Reset while in STALL.
    applyStimulus(1, 1, 1, 1, 2'b01, 0, 64'h500, 64'h0, 19'd0, 26'd4);
    checkOutput("k0 mid-rst flags", flags_k0, F_FLUSH);
    checkOutput("k0 mid-rst fetch_pc", fetch_pc_k0, 64'h0);
    checkOutput("k0 mid-rst sel", sel_k0, S_NONE);
    // BOOT ignores branch and stall.
    applyStimulus(0, 1, 1, 1, 2'b01, 0, 64'h500, 64'h0, 19'd0, 26'd4);
    checkOutput("k0 reboot flags", flags_k0, F_FLUSH);
    checkOutput("k0 reboot sel", sel_k0, S_NONE);
    checkOutput("k0 reboot cur_pc", cur_pc_k0, 64'h0);
`ifdef FETCH_CTRL_PERF_EN
    checkOutput("k0 perf cleared", 64'(pf_k0), 64'd0);
`endif
    idle(0, 1);
    checkOutput("k0 rerun flags", flags_k0, F_VALID);
    checkOutput("k0 rerun fetch_pc", fetch_pc_k0, 64'h0);

    // ---------------- KILL_SLOTS = 2 instance ----------------
    idle(1, 0);
    checkOutput("k2 boot flags", flags_k2, F_FLUSH);
    idle(1, 0);
    checkOutput("k2 run0 flags", flags_k2, F_VALID);
    idle(1, 0);
    checkOutput("k2 run4 fetch_pc", fetch_pc_k2, 64'h4);
    applyStimulus(1, 0, 0, 1, 2'b10, 0, 64'h8, 64'h100, 19'd0, 26'd0);
    checkOutput("k2 br flags", flags_k2, F_FLUSH);
    checkOutput("k2 br sel", sel_k2, S_ISBR);
    // SQUASH ignores branch and stall.
    applyStimulus(1, 0, 1, 1, 2'b01, 0, 64'h100, 64'h0, 19'd0, 26'd4);
    checkOutput("k2 sq1 flags", flags_k2, F_FLUSH);
    checkOutput("k2 sq1 sel", sel_k2, S_NONE);
    checkOutput("k2 sq1 fetch_pc", fetch_pc_k2, 64'h100);
    checkOutput("k2 sq1 cur_pc", cur_pc_k2, 64'h100);
    idle(1, 0);
    checkOutput("k2 sq2 flags", flags_k2, F_FLUSH);
    idle(1, 0);
    checkOutput("k2 target flags", flags_k2, F_VALID);
    checkOutput("k2 target fetch_pc", fetch_pc_k2, 64'h100);
    applyStimulus(1, 0, 0, 1, 2'b10, 0, 64'h104, 64'h300, 19'd0, 26'd0);
    checkOutput("k2 br2 fetch_pc", fetch_pc_k2, 64'h104);
    idle(1, 0);
    checkOutput("k2 sq1b fetch_pc", fetch_pc_k2, 64'h300);
    checkOutput("k2 sq1b flags", flags_k2, F_FLUSH);
    // Reset in the second SQUASH cycle.
    idle(1, 1);
    checkOutput("k2 sq-rst fetch_pc", fetch_pc_k2, 64'h0);
    checkOutput("k2 sq-rst flags", flags_k2, F_FLUSH);
    idle(1, 0);
    checkOutput("k2 reboot flags", flags_k2, F_FLUSH);
    checkOutput("k2 reboot fetch_pc", fetch_pc_k2, 64'h0);
    idle(1, 0);
    checkOutput("k2 rerun flags", flags_k2, F_VALID);
    checkOutput("k2 rerun fetch_pc", fetch_pc_k2, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the fetch-stage next-PC datapath in the 64-bit pipelined ARM CPU.
- Owns the architectural PC register and drives the datapath's select lines (is_BR, UncondBr, BrTaken) and its PC base.
- Consumes the datapath's next_pc.
- Arbitrates between sequential fetch, hazard stalls and branch redirects from the resolve stage.
- Generates IF/ID hold/flush and a fetch-valid qualifier.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- KILL_SLOTS, 0, extra bubble cycles after a taken redirect (0–7); models branch penalty beyond the flush cycle.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall_in  input  1  hazard-unit stall request (load-use).
- br_valid  input  1  a branch is resolved this cycle.
- br_kind  input  2  00 conditional (B.cond/CBZ), 01 unconditional B/BL, 10 register BR, 11 reserved (treated as not-taken).
- br_cond_true  input  1  condition result for br_kind=00.
- br_pc  input  64  PC of the resolving branch instruction.
- next_pc  input  64  datapath next-PC result.
- norm_result  input  64  datapath pc_base+4.
- cur_pc  output  64  PC base driven into the datapath.
- fetch_pc  output  64  registered PC being fetched (pc_q).
- is_BR  output  1  select register-target path.
- UncondBr  output  1  select Imm26 offset.
- BrTaken  output  1  select PC-relative branch target.
- fetch_valid  output  1  instruction at fetch_pc is to be written into IF/ID.
- ifid_hold  output  1  IF/ID register keeps its contents.
- ifid_flush  output  1  IF/ID register cleared to NOP.

Behaviour:
- States: BOOT, RUN, STALL, SQUASH. Internal registers: pc_q (64b), squash_cnt (3b).
- Reset (any state, any inputs): state=BOOT, pc_q=RESET_PC, squash_cnt=0.
- Reset values of outputs while reset is high:
  - fetch_valid=0, ifid_hold=0, ifid_flush=1.
  - is_BR=UncondBr=BrTaken=0.
  - cur_pc=fetch_pc=RESET_PC.
- Decode (combinational, only when br_valid and state is RUN or STALL):
  - taken = (kind==10) | (kind==01) | (kind==00 & br_cond_true).
  - is_BR = kind==10; UncondBr = kind==01; BrTaken = kind==01 | (kind==00 & br_cond_true).
- cur_pc = br_pc when taken, else pc_q.
- With no taken branch, all selects are 0, so next_pc=norm_result.
- BOOT:
  - One cycle; fetch_valid=0, ifid_flush=1.
  - pc_q holds. Next state RUN. br_valid and stall_in are ignored.
- RUN:
  - Taken branch: pc_q<=next_pc, ifid_flush=1, fetch_valid=0. Next state is SQUASH with squash_cnt<=KILL_SLOTS-1 if KILL_SLOTS>0, else RUN.
  - Otherwise, if stall_in: pc_q holds, ifid_hold=1, fetch_valid=0, next state STALL.
  - Otherwise: pc_q<=next_pc, fetch_valid=1.
- STALL:
  - Same priority as RUN: taken branch > stall_in > advance.
  - Stays while stall_in=1.
  - On the first cycle with stall_in=0: advance as RUN and return to RUN.
- SQUASH:
  - fetch_valid=0, ifid_flush=1, pc_q holds the target.
  - br_valid and stall_in are ignored (protocol: no older branch can resolve).
  - Decrement squash_cnt; leave for RUN in the cycle after squash_cnt reaches 0.
  - Total bubbles after a redirect = 1 + KILL_SLOTS.
- Simultaneous events:
  - Taken branch and stall_in together: redirect wins, stall is dropped (it belongs to a squashed younger instruction).
  - Not-taken branch and stall_in together: stall applies.
- Width: PC arithmetic is mod 2^64. A wrap from 0xFFFF_FFFF_FFFF_FFFC to 0 is legal and not flagged.
- Reset mid-operation (STALL/SQUASH): abandons all state the same cycle. Counters clear.

Optional Feature:
- FETCH_CTRL_PERF_EN.
- When defined, adds three 32-bit saturating counters, reset to 0:
  - perf_fetched: cycles with fetch_valid=1.
  - perf_redirects: taken branches.
  - perf_stall_cycles: cycles with ifid_hold=1.
- The counters are exposed as outputs of the same names.
- When undefined: no counters and no such ports. All other behaviour is identical.

Test Plan:
1. Reset for 2 cycles, RESET_PC=0, then release -> BOOT for 1 cycle with fetch_valid=0; then fetch_pc=0,4,8,C on consecutive cycles with fetch_valid=1.
2. At fetch_pc=0x10: br_valid, kind=00, cond_true=1, br_pc=0x8, datapath Imm19=3 -> BrTaken=1, cur_pc=0x8, ifid_flush=1 for 1 cycle, next fetch_pc=0x14. The same case with cond_true=0 -> no flush, fetch_pc advances 0x10->0x14 sequentially.
3. kind=10 with BR_addr=0x200 -> is_BR=1, fetch_pc=0x200. Then kind=01, br_pc=0x40, Imm26=26'h3FFFFFF -> UncondBr=1, fetch_pc=0x3C.
4. stall_in high for 3 cycles at fetch_pc=0x20 -> fetch_pc holds at 0x20, ifid_hold=1 and fetch_valid=0 for 3 cycles, then 0x24. With a taken branch in the 2nd stall cycle -> redirect taken, STALL exited, ifid_hold=0.
5. KILL_SLOTS=2, taken branch to 0x100 -> 3 cycles with fetch_valid=0, then fetch_pc=0x100 valid. Reset asserted in the 2nd SQUASH cycle -> fetch_pc=0, state BOOT.
6. With FETCH_CTRL_PERF_EN defined, run scenarios 1–4 -> perf_redirects=3, perf_stall_cycles=3 (with the interrupted-stall variant counted separately), perf_fetched equals the count of valid fetch cycles.
